// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline types: FSM encoding, instruction width and PC step.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // One queue entry: fetched word plus the address of the following word.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc_plus4;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH x W circular FIFO with flush; head is shown combinationally.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy update; flush empties the queue in one edge.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch over req/ack, redirect flush. Optional stats: FETCH_QUEUE_STATS_EN.
// Latency: request issues one cycle after reset/redirect; acked word reaches the head the next cycle.
// Backpressure: stall holds the head; fetching pauses (IDLE) once the queue would be full.
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_addr,
  input  logic               stall,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc_plus4,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  input  logic               mem_ack,
`ifdef FETCH_QUEUE_STATS_EN
  output logic [15:0]        discard_count,
  output logic [15:0]        stall_count,
`endif
  input  logic [INSTR_W-1:0] mem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   next_addr;
  logic [CW-1:0] count;
  logic [CW:0]   count_after_push;
  logic          push, pop, flush;
  fq_entry_t     wr_entry, head;

  assign next_addr        = mem_addr_q + PC_STEP;
  assign count_after_push = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
  assign wr_entry         = '{instr: mem_rdata, pc_plus4: next_addr};

  assign out_valid    = (count != '0);
  assign out_instr    = out_valid ? head.instr    : '0;
  assign out_pc_plus4 = out_valid ? head.pc_plus4 : '0;
  assign mem_req      = (state_q != IDLE);
  assign mem_addr     = mem_addr_q;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fq_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wr_entry),
    .count (count),
    .head  (head)
  );

  // Fetch FSM next-state: one outstanding request, redirect beats push/pop.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    flush      = 1'b0;
    pop        = out_valid && !stall && !redirect_valid;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_addr;
          mem_addr_d = redirect_addr;
          state_d    = REQ;
        end else if (count < CW'(DEPTH)) begin
          mem_addr_d = fetch_pc_q;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_addr;
          if (mem_ack) begin
            mem_addr_d = redirect_addr;
            state_d    = REQ;
          end else begin
            // Old request still in flight: keep its address until it acks.
            state_d = DISCARD;
          end
        end else if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = next_addr;
          if (count_after_push < (CW+1)'(DEPTH)) begin
            mem_addr_d = next_addr;
            state_d    = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_addr;
        end
        if (mem_ack) begin
          mem_addr_d = redirect_valid ? redirect_addr : fetch_pc_q;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, fetch PC and request address registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic drop;
  assign drop = mem_ack && (((state_q == REQ) && redirect_valid) || (state_q == DISCARD));

  // Saturating counters for dropped acks and stalled-head cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      discard_count <= '0;
      stall_count   <= '0;
    end else begin
      if (drop && (discard_count != 16'hFFFF))                 discard_count <= discard_count + 16'd1;
      if (out_valid && stall && (stall_count != 16'hFFFF))     stall_count   <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = 32'h0;
  logic        stall = 1'b0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] discard_count, stall_count;
  int          m_dc, m_sc;
`endif

  int checks = 0;
  int failures = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .stall          (stall),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc_plus4   (out_pc_plus4),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
`ifdef FETCH_QUEUE_STATS_EN
    .discard_count  (discard_count),
    .stall_count    (stall_count),
`endif
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // Memory responder: 2 = ack tied high, 1 = random ack, 0 = fixed latency.
  int   rmode = 2;
  int   lat = 0;
  int   rcnt = 0;
  logic req_seen = 1'b0;
  always @(posedge clk) begin
    #1;
    if ((mem_ack && req_seen) || !mem_req) rcnt = 0;
    req_seen = mem_req;
    if (rmode == 2)      mem_ack = 1'b1;
    else if (rmode == 1) mem_ack = 1'($urandom_range(0, 1));
    else begin
      mem_ack = mem_req && (rcnt >= lat);
      if (mem_req) rcnt++;
    end
    mem_rdata = imem(mem_addr);
  end

  // Reference model: queue of expected entries, expected fetch address, discard flag.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;
  ent_t        q[$];
  logic [31:0] exp_pc = 32'h0;
  bit          disc = 0;
  bit          pend = 0;
  logic [31:0] paddr = 32'h0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_pc = 32'h0;
      disc = 0;
      pend = 0;
`ifdef FETCH_QUEUE_STATS_EN
      m_dc = 0;
      m_sc = 0;
`endif
    end else begin
      chk("m_valid", out_valid, (q.size() != 0));
      if (q.size() != 0) begin
        chk("m_instr", out_instr, q[0].instr);
        chk("m_pc4", out_pc_plus4, q[0].pc4);
      end
      if (mem_req && !disc) chk("m_addr", mem_addr, exp_pc);
      if (pend) begin
        chk("m_req_hold", mem_req, 1);
        chk("m_addr_hold", mem_addr, paddr);
      end
      if (q.size() == DEPTH) chk("m_full_idle", mem_req, 0);
`ifdef FETCH_QUEUE_STATS_EN
      chk("m_discard_cnt", discard_count, m_dc);
      chk("m_stall_cnt", stall_count, m_sc);
      if (q.size() != 0 && stall && m_sc < 16'hFFFF) m_sc++;
      if (mem_req && mem_ack && (disc || redirect_valid) && m_dc < 16'hFFFF) m_dc++;
`endif
      // Advance the model across the coming clock edge.
      if (redirect_valid) begin
        q.delete();
        exp_pc = redirect_addr;
        disc = mem_req && !mem_ack;
      end else begin
        if (q.size() != 0 && !stall) void'(q.pop_front());
        if (mem_req && mem_ack) begin
          if (disc) disc = 0;
          else begin
            q.push_back('{imem(mem_addr), mem_addr + 32'd4});
            exp_pc = mem_addr + 32'd4;
            chk("m_bound", (q.size() <= DEPTH), 1);
          end
        end
      end
      pend = mem_req && !mem_ack;
      paddr = mem_addr;
    end
  end

  initial begin
    bit found;
    tick(1);

    // Streaming with ack tied high.
    rmode = 2; stall = 0;
    do_reset();
    @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc4", out_pc_plus4, 0);
    @(negedge clk);
    chk("t1_req", mem_req, 1);
    chk("t1_addr0", mem_addr, 32'h0);
    @(negedge clk);
    chk("t1_pc4_a", out_pc_plus4, 32'h4);
    chk("t1_instr_a", out_instr, 32'hC0DE_5A5A);
    chk("t1_addr4", mem_addr, 32'h4);
    @(negedge clk);
    chk("t1_pc4_b", out_pc_plus4, 32'h8);
    @(negedge clk);
    chk("t1_pc4_c", out_pc_plus4, 32'hC);
    chk("t1_valid", out_valid, 1);

    // Stall fills the queue, fetch pauses, release resumes at 0x10.
    tick(1);
    stall = 1;
    do_reset();
    tick(10);
    @(negedge clk);
    chk("t2_idle", mem_req, 0);
    chk("t2_head", out_pc_plus4, 32'h4);
    tick(1);
    stall = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (mem_req) found = 1;
    end
    chk("t2_resume_seen", found, 1);
    chk("t2_resume_addr", mem_addr, 32'h10);

    // Redirect while a slow request to 0x8 is pending.
    tick(1);
    stall = 1; rmode = 0; lat = 3;
    do_reset();
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick(1);
      if (mem_req && mem_addr == 32'h8) found = 1;
    end
    chk("t3_req8_seen", found, 1);
    redirect_valid = 1; redirect_addr = 32'h100;
    tick(1);
    redirect_valid = 0;
    @(negedge clk);
    chk("t3_flush", out_valid, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr != 32'h8) found = 1;
    end
    chk("t3_new_seen", found, 1);
    chk("t3_new_addr", mem_addr, 32'h100);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (out_valid) found = 1;
    end
    chk("t3_fill_seen", found, 1);
    chk("t3_pc4", out_pc_plus4, 32'h104);

    // Redirect coinciding with the ack for 0xC.
    tick(1);
    rmode = 2;
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (mem_req && mem_addr == 32'hC) found = 1;
    end
    chk("t4_reqC_seen", found, 1);
    redirect_valid = 1; redirect_addr = 32'h40;
    tick(1);
    redirect_valid = 0;
    @(negedge clk);
    chk("t4_flush", out_valid, 0);
    chk("t4_addr", mem_addr, 32'h40);
    @(negedge clk);
    chk("t4_pc4", out_pc_plus4, 32'h44);

    // Address wrap at the top of memory.
    tick(1);
    redirect_valid = 1; redirect_addr = 32'hFFFF_FFFC;
    tick(1);
    redirect_valid = 0;
    @(negedge clk);
    chk("t5_addr", mem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("t5_pc4_wrap", out_pc_plus4, 32'h0);
    chk("t5_instr", out_instr, imem(32'hFFFF_FFFC));
    chk("t5_next_addr", mem_addr, 32'h0);

    // Random ack/stall/redirect traffic against the model.
    tick(1);
    rmode = 1;
    for (int i = 0; i < 1000; i++) begin
      stall = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      tick(1);
    end
    redirect_valid = 0; stall = 0; rmode = 2;
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
